// File: rtl/exe_div_stage_if.sv
// Execute-stage port bundle: upstream decode handshake, downstream memory-stage
// handshake, data SRAM request channel and the two exception/flush inputs.
interface exe_div_stage_if;
    logic         ds_to_es_valid;
    logic         es_allowin;
    logic [106:0] ds_to_es_bus;
    logic         ms_allowin;
    logic         es_to_ms_valid;
    logic [70:0]  es_to_ms_bus;
    logic         data_sram_req;
    logic         data_sram_wr;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic         data_sram_addr_ok;
    logic         ms_ex;
    logic         ws_ex;

    // Environment side: drives upstream/downstream/SRAM inputs.
    modport master (
        output ds_to_es_valid, ds_to_es_bus, ms_allowin, data_sram_addr_ok, ms_ex, ws_ex,
        input  es_allowin, es_to_ms_valid, es_to_ms_bus,
               data_sram_req, data_sram_wr, data_sram_addr, data_sram_wdata
    );

    // Stage side.
    modport slave (
        input  ds_to_es_valid, ds_to_es_bus, ms_allowin, data_sram_addr_ok, ms_ex, ws_ex,
        output es_allowin, es_to_ms_valid, es_to_ms_bus,
               data_sram_req, data_sram_wr, data_sram_addr, data_sram_wdata
    );
endinterface

// File: rtl/exe_div_stage.sv
// Execute pipeline stage: single-cycle ALU, LD.W/ST.W address request, and a
// 32-cycle restoring radix-2 divider for DIV.W/MOD.W/DIV.WU/MOD.WU.
module exe_div_stage (
    input  logic             clk,
    input  logic             reset,
    exe_div_stage_if.slave   es_if
);

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_AND    = 5'd2;
    localparam logic [4:0] OP_OR     = 5'd3;
    localparam logic [4:0] OP_LD_W   = 5'd4;
    localparam logic [4:0] OP_ST_W   = 5'd5;
    localparam logic [4:0] OP_DIV_W  = 5'd8;
    localparam logic [4:0] OP_MOD_W  = 5'd9;
    localparam logic [4:0] OP_DIV_WU = 5'd10;
    localparam logic [4:0] OP_MOD_WU = 5'd11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } div_state_e;

    // Control state (reset)
    logic         es_valid_q, es_valid_d;
    div_state_e   state_q, state_d;
    logic [4:0]   cnt_q, cnt_d;
    logic         req_done_q, req_done_d;

    // Datapath state (not reset)
    logic [106:0] es_bus_q, es_bus_d;
    logic [31:0]  quot_q, quot_d;
    logic [31:0]  rem_q, rem_d;
    logic [31:0]  dvsr_q, dvsr_d;
    logic         q_neg_q, q_neg_d;
    logic         r_neg_q, r_neg_d;

    // Bus fields of the instruction held in this stage
    logic [4:0]   op;
    logic         gr_we;
    logic [4:0]   dest;
    logic [31:0]  src1, src2, pc;

    assign op    = es_bus_q[106:102];
    assign gr_we = es_bus_q[101];
    assign dest  = es_bus_q[100:96];
    assign src1  = es_bus_q[95:64];
    assign src2  = es_bus_q[63:32];
    assign pc    = es_bus_q[31:0];

    logic is_div, is_signed, is_ld, is_st, is_mem;
    logic ready_go, handoff;
    logic [31:0] mem_addr;

    assign is_div    = (op == OP_DIV_W) || (op == OP_MOD_W) || (op == OP_DIV_WU) || (op == OP_MOD_WU);
    assign is_signed = (op == OP_DIV_W) || (op == OP_MOD_W);
    assign is_ld     = (op == OP_LD_W);
    assign is_st     = (op == OP_ST_W);
    assign is_mem    = is_ld || is_st;
    assign mem_addr  = src1 + src2;

    // SRAM request: one outstanding request per instruction, suppressed by exceptions
    assign es_if.data_sram_req   = es_valid_q && is_mem && !req_done_q && !es_if.ms_ex && !es_if.ws_ex;
    assign es_if.data_sram_wr    = is_st;
    assign es_if.data_sram_addr  = mem_addr;
    assign es_if.data_sram_wdata = src2;

    // Per-class completion condition
    always_comb begin
        ready_go = 1'b1;
        if (is_div) begin
            ready_go = (state_q == S_DONE);
        end else if (is_mem) begin
            ready_go = (es_if.data_sram_req && es_if.data_sram_addr_ok) || req_done_q || es_if.ms_ex;
        end
    end

    assign es_if.es_allowin     = !es_valid_q || (ready_go && es_if.ms_allowin);
    assign es_if.es_to_ms_valid = es_valid_q && ready_go && !es_if.ws_ex;
    assign handoff              = es_if.es_to_ms_valid && es_if.ms_allowin;

    // One restoring step: shift in the next dividend bit, subtract if it fits
    logic [32:0] rem_shift;
    logic [31:0] rem_sub;
    logic        step_ge;

    assign rem_shift = {rem_q, quot_q[31]};
    assign rem_sub   = rem_shift[31:0] - dvsr_q;
    assign step_ge   = rem_shift[32] || (rem_shift[31:0] >= dvsr_q);

    // Pipeline valid, bus capture and SRAM handshake bookkeeping
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        es_valid_d = es_valid_q;
        es_bus_d   = es_bus_q;
        req_done_d = req_done_q;
        if (es_if.ws_ex) begin
            es_valid_d = 1'b0;
        end else if (es_if.es_allowin) begin
            es_valid_d = es_if.ds_to_es_valid;
        end
        if (es_if.ds_to_es_valid && es_if.es_allowin) begin
            es_bus_d = es_if.ds_to_es_bus;
        end
        if (es_if.ws_ex || handoff) begin
            req_done_d = 1'b0;
        end else if (es_if.data_sram_req && es_if.data_sram_addr_ok) begin
            req_done_d = 1'b1;
        end
    end

    // Divider FSM: operand capture, 32 restoring steps, hold result until handoff
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dvsr_d  = dvsr_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        if (es_if.ws_ex) begin
            state_d = S_IDLE;
            cnt_d   = 5'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_d = 5'd0;
                    if (es_valid_q && is_div) begin
                        state_d = S_BUSY;
                        quot_d  = (is_signed && src1[31]) ? -src1 : src1;
                        dvsr_d  = (is_signed && src2[31]) ? -src2 : src2;
                        rem_d   = 32'd0;
                        q_neg_d = is_signed && (src1[31] ^ src2[31]);
                        r_neg_d = is_signed && src1[31];
                    end
                end
                S_BUSY: begin
                    rem_d  = step_ge ? rem_sub : rem_shift[31:0];
                    quot_d = {quot_q[30:0], step_ge};
                    cnt_d  = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (handoff) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Sign fixup and divide-by-zero override (zero divisor keeps the raw dividend)
    logic        dvsr_zero;
    logic [31:0] div_quot, div_rem;

    assign dvsr_zero = (src2 == 32'd0);
    assign div_quot  = dvsr_zero ? 32'hFFFF_FFFF : (q_neg_q ? -quot_q : quot_q);
    assign div_rem   = dvsr_zero ? src1 : (r_neg_q ? -rem_q : rem_q);

    // Result select
    logic [31:0] result;
    always_comb begin
        result = 32'd0;
        case (op)
            OP_ADD:                result = src1 + src2;
            OP_SUB:                result = src1 - src2;
            OP_AND:                result = src1 & src2;
            OP_OR:                 result = src1 | src2;
            OP_LD_W, OP_ST_W:      result = mem_addr;
            OP_DIV_W, OP_DIV_WU:   result = div_quot;
            OP_MOD_W, OP_MOD_WU:   result = div_rem;
            default:               result = 32'd0;
        endcase
    end

    assign es_if.es_to_ms_bus = {is_ld, gr_we && !is_st, dest, result, pc};

    // Control registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
        if (!reset) begin
            es_valid_q <= 1'b0;
            state_q    <= S_IDLE;
            cnt_q      <= 5'd0;
            req_done_q <= 1'b0;
        end else begin
            es_valid_q <= es_valid_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_done_q <= req_done_d;
        end
    end

    // Datapath registers: qualified by the control state, so they need no reset
    always_ff @(posedge clk) begin
        // NOTE: payload/divider registers are deliberately unreset; es_valid_q and state_q gate their use.
        es_bus_q <= es_bus_d;
        quot_q   <= quot_d;
        rem_q    <= rem_d;
        dvsr_q   <= dvsr_d;
        q_neg_q  <= q_neg_d;
        r_neg_q  <= r_neg_d;
    end

endmodule

// File: doc/exe_div_stage.md
EXE_DIV_STAGE -- requirements
Module: exe_div_stage

Interface
REQ-001 SHALL have ports: clk  in  1  clock; all state updates on posedge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-low (0 = reset asserted, sampled on posedge clk).
REQ-003 SHALL have ports: ds_to_es_valid in 1 upstream valid; es_allowin out 1 stage can accept; ds_to_es_bus in 107 {op[106:102], gr_we[101], dest[100:96], src1[95:64], src2[63:32], pc[31:0]}.
REQ-004 SHALL have ports: ms_allowin in 1 downstream accept; es_to_ms_valid out 1; es_to_ms_bus out 71 {res_from_mem[70], gr_we[69], dest[68:64], result[63:32], pc[31:0]}.
REQ-005 SHALL have ports: data_sram_req out 1; data_sram_wr out 1; data_sram_addr out 32; data_sram_wdata out 32; data_sram_addr_ok in 1 (request accepted this cycle).
REQ-006 SHALL have ports: ms_ex in 1 exception/ertn in mem stage; ws_ex in 1 flush from writeback.

Function
REQ-007 SHALL decode op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 LD.W, 5 ST.W, 8 DIV.W, 9 MOD.W, 10 DIV.WU, 11 MOD.WU; any other code -> result 0, single cycle.
REQ-008 SHALL latch ds_to_es_bus when ds_to_es_valid && es_allowin; es_valid <= ds_to_es_valid when es_allowin; es_valid <= 0 when ws_ex (priority over load).
REQ-009 SHALL drive es_allowin = !es_valid || (ready_go && ms_allowin); es_to_ms_valid = es_valid && ready_go && !ws_ex.
REQ-010 ALU ops SHALL have ready_go = 1 (1-cycle); arithmetic modulo 2^32; LD/ST address = src1 + src2.
REQ-011 Divider FSM states IDLE, BUSY, DONE; IDLE->BUSY when es_valid && div op && !ws_ex, latching |src1|, |src2| (signed ops) or raw values (unsigned) and signs; counter = 0.
REQ-012 BUSY SHALL perform one restoring radix-2 step per cycle, 32 cycles total (counter 0..31), then ->DONE.
REQ-013 DONE SHALL assert ready_go; DONE->IDLE on handoff (es_to_ms_valid && ms_allowin); DONE holds while ms_allowin = 0.
REQ-014 Signed fixup: quotient negated when operand signs differ; remainder takes sign of src1.
REQ-015 Divide by zero: quotient 0xFFFFFFFF, remainder = src1, all four div ops.
REQ-016 Overflow 0x80000000 / 0xFFFFFFFF (DIV.W) -> quotient 0x80000000, remainder 0.
REQ-017 ws_ex in any FSM state SHALL force IDLE next cycle, discarding partial result.
REQ-018 LD/ST: data_sram_req = es_valid && mem op && !req_done && !ms_ex && !ws_ex; data_sram_wr = 1 for ST.W; wdata = src2; addr stable while req high.
REQ-019 Mem op ready_go = (data_sram_req && data_sram_addr_ok) || req_done || ms_ex; req_done set on handshake without handoff, cleared on handoff or ws_ex.
REQ-020 res_from_mem = 1 only for LD.W; gr_we forwarded from bus except forced 0 for ST.W.
REQ-021 Back-to-back: new instruction SHALL be accepted in the same cycle the previous one hands off.

Reset
REQ-022 While reset = 0: es_valid = 0, FSM = IDLE, counter = 0, req_done = 0; hence es_allowin = 1, es_to_ms_valid = 0, data_sram_req = 0; bus registers are don't-care.
REQ-023 Reset asserted mid-division SHALL abandon it; first cycle after release behaves as idle.

Verification
REQ-024 ADD src1=5, src2=0xFFFFFFFF, ms_allowin=1 -> es_to_ms_valid next cycle, result 4, 1-cycle throughput on back-to-back ADDs.
REQ-025 DIV.W src1=-7, src2=2 -> ready_go 33 cycles after entry, result 0xFFFFFFFD; MOD.W same operands -> 0xFFFFFFFF; es_allowin = 0 throughout.
REQ-026 DIV.WU src1=0x12345678, src2=0 -> 0xFFFFFFFF; MOD.WU -> 0x12345678; DIV.W 0x80000000/0xFFFFFFFF -> 0x80000000.
REQ-027 ST.W with addr_ok low 3 cycles, ms_allowin low 2 further cycles -> req high exactly until handshake, single request, handoff when ms_allowin rises.
REQ-028 ws_ex pulse at BUSY cycle 10 -> es_valid 0, FSM IDLE next cycle, no es_to_ms_valid; next DIV yields correct result.
REQ-029 LD.W with ms_ex = 1 -> no data_sram_req, instruction passes in 1 cycle; reset low mid-DIV -> outputs at reset values.
